// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared SPI mode constants, default idle word and FSM state type
package spi_slave_pkg;

    // SPI modes as {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // Word shifted out when the host has not supplied one (sliced to DW bits)
    localparam logic [31:0] TX_IDLE_DEFAULT = 32'h0000_00FF;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/spi_slave_sync.sv
// rtl/spi_slave_sync.sv - two-flop synchronizer with a third flop for lead/trail edge pulses
module spi_slave_sync
    import spi_slave_pkg::*;
#(
    parameter logic IDLE    = 1'b0,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic lead,
    output logic trail
);

    logic [2:0] sr;

    // sr[1] is the synchronized level, sr[2] its previous value for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= {3{RST_VAL}};
        end else begin
            sr <= {sr[1:0], pin};
        end
    end

    // lead: level leaves IDLE; trail: level returns to IDLE
    assign lead  = (sr[1] != IDLE) && (sr[2] == IDLE);
    assign trail = (sr[1] == IDLE) && (sr[2] != IDLE);

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampled SPI target with pulsed rx port and one-deep tx hold buffer
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int            DW      = 8,
    parameter logic          CPOL    = SPI_MODE0[1],
    parameter logic          CPHA    = SPI_MODE0[0],
    parameter logic [DW-1:0] TX_IDLE = TX_IDLE_DEFAULT[DW-1:0]
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          spi_sck,
    input  logic          spi_ss,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic          spi_miso_oe,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    output logic          tx_underrun,
    output logic          busy
);

    localparam int CW = (DW > 2) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

    state_t        state;
    state_t        state_nxt;
    logic          sck_lead;
    logic          sck_trail;
    logic          ss_fall;
    logic          ss_rise;
    logic [1:0]    mosi_sr;
    logic          mosi_s;
    logic [CW-1:0] bit_cnt;
    logic          frame_first;
    logic [DW-1:0] rx_shift;
    logic [DW-1:0] tx_shift;
    logic [DW-1:0] hold;
    logic          hold_full;
    logic          in_frame;
    logic          start;
    logic          do_sample;
    logic          do_shift;
    logic          reload;
    logic          accept;
    logic [DW-1:0] rx_next;

    // SCK resets to its idle level so leaving reset never fakes an edge
    spi_slave_sync #(.IDLE(CPOL), .RST_VAL(CPOL)) u_sck_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (spi_sck),
        .lead  (sck_lead),
        .trail (sck_trail)
    );

    // SS resets low so a reset inside a frame cannot see a falling edge until SS has gone high
    spi_slave_sync #(.IDLE(1'b1), .RST_VAL(1'b0)) u_ss_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (spi_ss),
        .lead  (ss_fall),
        .trail (ss_rise)
    );

    // Two-flop synchronizer for MOSI; sampled together with the three-flop SCK edge
    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_sr <= 2'b00;
        end else begin
            mosi_sr <= {mosi_sr[0], spi_mosi};
        end
    end

    assign mosi_s = mosi_sr[1];

    // An SS deassert in the same clk as an SCK edge wins, so edges only count while staying selected
    assign in_frame  = (state == ST_ACTIVE) && !ss_rise;
    assign start     = (state == ST_IDLE) && ss_fall;
    assign do_sample = in_frame && (CPHA ? sck_trail : sck_lead);
    assign do_shift  = in_frame && (CPHA ? sck_lead : sck_trail);
    assign reload    = start || (do_shift && !frame_first && (bit_cnt == '0));
    assign accept    = tx_valid && !hold_full;
    assign rx_next   = {rx_shift[DW-2:0], mosi_s};

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: selected while synchronized SS is low
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (ss_fall) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (ss_rise) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Bit counter, shift registers, hold buffer and pulsed status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= '0;
            frame_first <= 1'b0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;

            if (reload) begin
                if (hold_full) begin
                    tx_shift  <= hold;
                    hold_full <= 1'b0;
                end else if (tx_valid) begin
                    tx_shift <= tx_data;
                end else begin
                    tx_shift    <= TX_IDLE;
                    tx_underrun <= 1'b1;
                end
            end else begin
                if (accept) begin
                    hold      <= tx_data;
                    hold_full <= 1'b1;
                end
                if (do_shift && !frame_first) begin
                    tx_shift <= {tx_shift[DW-2:0], 1'b0};
                end
            end

            if (do_shift && frame_first) begin
                frame_first <= 1'b0;
            end

            if (do_sample) begin
                rx_shift    <= rx_next;
                frame_first <= 1'b0;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt  <= '0;
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            if (start) begin
                bit_cnt     <= '0;
                frame_first <= 1'b1;
            end else if ((state == ST_ACTIVE) && ss_rise) begin
                bit_cnt <= '0;
            end
        end
    end

    assign tx_ready    = !hold_full;
    assign spi_miso    = (state == ST_ACTIVE) && tx_shift[DW-1];
    assign spi_miso_oe = (state == ST_ACTIVE);
    assign busy        = (state == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - scoreboard bench driving mode 0 and mode 3 instances from one bench master
module tb_spi_slave;
    import spi_slave_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       sck_phase = 1'b0;
    logic       mosi = 1'b0;
    logic       ss0 = 1'b1;
    logic       ss3 = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid0 = 1'b0;
    logic       tx_valid3 = 1'b0;

    logic       miso0, oe0, tx_ready0, rx_valid0, und0, busy0;
    logic       miso3, oe3, tx_ready3, rx_valid3, und3, busy3;
    logic [7:0] rx_data0, rx_data3;

    spi_slave #(.DW(8), .CPOL(SPI_MODE0[1]), .CPHA(SPI_MODE0[0]), .TX_IDLE(8'hFF)) dut0 (
        .clk(clk), .rst(rst), .spi_sck(sck_phase), .spi_ss(ss0), .spi_mosi(mosi),
        .spi_miso(miso0), .spi_miso_oe(oe0), .tx_data(tx_data), .tx_valid(tx_valid0),
        .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .tx_underrun(und0), .busy(busy0)
    );

    spi_slave #(.DW(8), .CPOL(SPI_MODE3[1]), .CPHA(SPI_MODE3[0]), .TX_IDLE(8'hFF)) dut3 (
        .clk(clk), .rst(rst), .spi_sck(~sck_phase), .spi_ss(ss3), .spi_mosi(mosi),
        .spi_miso(miso3), .spi_miso_oe(oe3), .tx_data(tx_data), .tx_valid(tx_valid3),
        .tx_ready(tx_ready3), .rx_data(rx_data3), .rx_valid(rx_valid3),
        .tx_underrun(und3), .busy(busy3)
    );

    int errors = 0;
    int checks = 0;

    // reference model: per-instance hold buffer, expected underruns, last received word
    logic       hold_full [2];
    logic [7:0] hold_val  [2];
    int         und_exp   [2];
    int         und_seen  [2];
    logic [7:0] last_rx   [2];
    logic [7:0] rx_exp0 [$];
    logic [7:0] rx_exp3 [$];
    logic [7:0] miso_exp [$];
    logic [7:0] miso_cap;
    event       miso_ev;

    logic [7:0] fw [4];
    logic       fe [4];
    logic [7:0] fv [4];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic o_miso(input int i);     return i != 0 ? miso3 : miso0;         endfunction
    function automatic logic o_oe(input int i);       return i != 0 ? oe3 : oe0;             endfunction
    function automatic logic o_ready(input int i);    return i != 0 ? tx_ready3 : tx_ready0; endfunction
    function automatic logic o_busy(input int i);     return i != 0 ? busy3 : busy0;         endfunction
    function automatic logic o_rxv(input int i);      return i != 0 ? rx_valid3 : rx_valid0; endfunction
    function automatic logic o_und(input int i);      return i != 0 ? und3 : und0;           endfunction
    function automatic logic [7:0] o_rxd(input int i); return i != 0 ? rx_data3 : rx_data0;  endfunction

    // rx monitor and underrun counter, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid0) begin
                if (rx_exp0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rx0_unexpected: got %0h expected no word", rx_data0);
                end else chk("rx0_data", 32'(rx_data0), 32'(rx_exp0.pop_front()));
            end
            if (rx_valid3) begin
                if (rx_exp3.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rx3_unexpected: got %0h expected no word", rx_data3);
                end else chk("rx3_data", 32'(rx_data3), 32'(rx_exp3.pop_front()));
            end
            if (und0) und_seen[0]++;
            if (und3) und_seen[1]++;
        end
    end

    // miso monitor: word assembled by the bench master
    always @(miso_ev) begin
        if (miso_exp.size() == 0) begin
            checks++; errors++;
            $display("FAIL miso_unexpected: got %0h expected no word", miso_cap);
        end else chk("miso_word", 32'(miso_cap), 32'(miso_exp.pop_front()));
    end

    task automatic set_ss(input int i, input logic v);
        if (i != 0) ss3 = v; else ss0 = v;
    endtask

    task automatic feed(input int i, input logic [7:0] v);
        chk("tx_ready_before_write", 32'(o_ready(i)), 32'(!hold_full[i]));
        tx_data = v;
        if (i != 0) tx_valid3 = 1'b1; else tx_valid0 = 1'b1;
        wclk(1);
        tx_valid0 = 1'b0;
        tx_valid3 = 1'b0;
        hold_val[i]  = v;
        hold_full[i] = 1'b1;
    endtask

    task automatic mload(input int i, output logic [7:0] cur);
        if (hold_full[i]) begin
            cur = hold_val[i];
            hold_full[i] = 1'b0;
        end else begin
            cur = 8'hFF;
            und_exp[i]++;
        end
    endtask

    task automatic reset_checks(input int i);
        chk("rst_miso", 32'(o_miso(i)), 0);
        chk("rst_miso_oe", 32'(o_oe(i)), 0);
        chk("rst_tx_ready", 32'(o_ready(i)), 1);
        chk("rst_rx_data0", 32'(rx_data0), 0);
        chk("rst_rx_data3", 32'(rx_data3), 0);
        chk("rst_rx_valid", 32'(o_rxv(i)), 0);
        chk("rst_tx_underrun", 32'(o_und(i)), 0);
        chk("rst_busy", 32'(o_busy(i)), 0);
        for (int k = 0; k < 2; k++) begin
            hold_full[k] = 1'b0;
            last_rx[k]   = 8'h00;
        end
    endtask

    // one word, MSB first; instance 0 is mode 0, instance 1 is mode 3
    task automatic xfer(input int i, input logic [7:0] w, input int nbits, input logic fen,
                        input logic [7:0] fval, input int rst_bit, input logic chk_miso);
        logic [7:0] cap = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            if (i == 0) begin
                mosi = w[7-b];
                if (b == 3 && fen) begin feed(i, fval); wclk(4); end else wclk(5);
                sck_phase = 1'b1;
                cap = {cap[6:0], o_miso(i)};
            end else begin
                sck_phase = 1'b1;
                mosi = w[7-b];
                if (b == 3 && fen) begin feed(i, fval); wclk(4); end else wclk(5);
                sck_phase = 1'b0;
                cap = {cap[6:0], o_miso(i)};
            end
            if (b == rst_bit) begin
                rst = 1'b1;
                wclk(1);
                reset_checks(i);
                rst = 1'b0;
                wclk(4);
            end else wclk(5);
            if (i == 0) sck_phase = 1'b0;
        end
        if (chk_miso) begin
            miso_cap = cap;
            ->miso_ev;
        end
    endtask

    task automatic ss_fall(input int i, output logic [7:0] cur);
        wclk(2);
        set_ss(i, 1'b0);
        mload(i, cur);
        wclk(6);
        chk("busy_selected", 32'(o_busy(i)), 1);
        chk("miso_oe_selected", 32'(o_oe(i)), 1);
        chk("tx_ready_at_ss_fall", 32'(o_ready(i)), 32'(!hold_full[i]));
    endtask

    task automatic ss_rise(input int i);
        wclk(4);
        set_ss(i, 1'b1);
        wclk(6);
        chk("busy_idle", 32'(o_busy(i)), 0);
        chk("miso_oe_idle", 32'(o_oe(i)), 0);
        chk("miso_idle", 32'(o_miso(i)), 0);
        chk("rx_data_held", 32'(o_rxd(i)), 32'(last_rx[i]));
        chk("underrun_count", 32'(und_seen[i]), 32'(und_exp[i]));
        chk("rx_queue_drained", 32'(i != 0 ? rx_exp3.size() : rx_exp0.size()), 0);
    endtask

    task automatic run_frame(input int i, input int nw, input logic pre_en, input logic [7:0] pre_v);
        logic [7:0] cur;
        if (pre_en && !hold_full[i]) feed(i, pre_v);
        ss_fall(i, cur);
        for (int w = 0; w < nw; w++) begin
            miso_exp.push_back(cur);
            if (i != 0) rx_exp3.push_back(fw[w]); else rx_exp0.push_back(fw[w]);
            xfer(i, fw[w], 8, fe[w], fv[w], -1, 1'b1);
            last_rx[i] = fw[w];
            // CPHA=0 reloads on the trailing edge after every word, CPHA=1 only before the next word
            if (i == 0 || w < nw - 1) mload(i, cur);
        end
        ss_rise(i);
    endtask

    initial begin
        logic [7:0] cur;
        for (int k = 0; k < 2; k++) begin
            hold_full[k] = 1'b0; hold_val[k] = 8'h00; und_exp[k] = 0;
            und_seen[k] = 0; last_rx[k] = 8'h00;
        end
        wclk(3);
        reset_checks(0);
        reset_checks(1);
        rst = 1'b0;
        wclk(8);

        // mode 0 single word
        fw[0] = 8'hA5; fe[0] = 1'b0; fv[0] = 8'h00;
        run_frame(0, 1, 1'b1, 8'h3C);

        // mode 0 back-to-back with refill during the first word
        fw[0] = 8'h11; fe[0] = 1'b1; fv[0] = 8'hAA;
        fw[1] = 8'h22; fe[1] = 1'b0;
        run_frame(0, 2, 1'b1, 8'h55);

        // mode 3 underrun
        fw[0] = 8'h5A; fe[0] = 1'b0;
        run_frame(1, 1, 1'b0, 8'h00);

        // mode 0 abort after 5 SCK cycles, hold written during the aborted word is retained
        ss_fall(0, cur);
        xfer(0, 8'hC6, 5, 1'b1, 8'h77, -1, 1'b0);
        ss_rise(0);
        chk("hold_retained_after_abort", 32'(tx_ready0), 0);
        fw[0] = 8'h0B; fe[0] = 1'b0;
        run_frame(0, 1, 1'b0, 8'h00);

        // mode 3 exchange
        fw[0] = 8'h0B; fe[0] = 1'b0;
        run_frame(1, 1, 1'b1, 8'hC3);

        // reset mid-word; the rest of the frame must be ignored
        feed(0, 8'h99);
        ss_fall(0, cur);
        xfer(0, 8'hE7, 8, 1'b0, 8'h00, 4, 1'b0);
        ss_rise(0);
        fw[0] = 8'h3A; fe[0] = 1'b0;
        run_frame(0, 1, 1'b0, 8'h00);

        // randomized frames on both modes
        for (int n = 0; n < 14; n++) begin
            int i;
            int nw;
            logic pre;
            i  = int'($urandom_range(0, 1));
            nw = int'($urandom_range(1, 3));
            for (int w = 0; w < 4; w++) begin
                fw[w] = 8'($urandom);
                fe[w] = 1'($urandom);
                fv[w] = 8'($urandom);
            end
            pre = 1'($urandom);
            run_frame(i, nw, pre, 8'($urandom));
        end

        wclk(5);
        chk("miso_queue_drained", 32'(miso_exp.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
